// File: rtl/mmio_resp_pkg.sv
// Shared constants and types for the MMIO responder slice.
//  - RAM_* : load/store port action encodings
//  - MMIO_* : byte offsets of the local registers inside the MMIO window
//  - tx_state_e : console serial shifter states
//  - con_stat_t : layout of the CON_STAT read value
package mmio_resp_pkg;

  localparam logic [1:0] RAM_NOP = 2'd0;
  localparam logic [1:0] RAM_LD  = 2'd1;
  localparam logic [1:0] RAM_ST  = 2'd2;

  localparam logic [7:0] MMIO_CON_DATA = 8'h00;
  localparam logic [7:0] MMIO_CON_STAT = 8'h04;
  localparam logic [7:0] MMIO_CYCLE    = 8'h08;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned BITS_PER_CHAR = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        ovf;
    logic        full;
    logic        busy;
  } con_stat_t;

endpackage

// File: rtl/con_tx.sv
// Console transmitter: byte FIFO feeding an 8N1 serial shifter.
// Ports:
//  i_clk, i_rst   clock, synchronous active-high reset
//  i_push, i_byte byte write request
//  o_full         FIFO holds FIFO_DEPTH bytes
//  o_busy         FIFO non-empty or a frame in flight
//  o_ovf_pulse    same-cycle indication that the pushed byte was dropped
//  o_tx           serial line, idles high
module con_tx
  import mmio_resp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_DIV   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_byte,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_ovf_pulse,
  output logic       o_tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, full_q, full_d, busy_q, busy_d;
  logic          pop, accept, baud_end, fifo_ne;

  // Shifter sequencing, FIFO bookkeeping and next line value.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    pop         = 1'b0;
    fifo_ne     = (cnt_q != '0);
    baud_end    = (baud_q == BW'(BAUD_DIV - 1));

    unique case (state_q)
      TX_IDLE: begin
        if (fifo_ne) pop = 1'b1;
      end
      TX_START: begin
        if (baud_end) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          sh_d   = sh_q >> 1;
          bit_d  = bit_q + 3'(1);
          if (bit_q == 3'(BITS_PER_CHAR - 1)) state_d = TX_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (fifo_ne) pop = 1'b1;
          else         state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (pop) begin
      state_d = TX_START;
      baud_d  = '0;
      sh_d    = mem_q[rd_q];
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still take a byte.
    accept      = i_push && ((cnt_q < CW'(FIFO_DEPTH)) || pop);
    o_ovf_pulse = i_push && !accept;

    wr_d  = accept ? wr_q + PW'(1) : wr_q;
    rd_d  = pop    ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(accept) - CW'(pop);

    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = sh_d[0];
      default:  tx_d = 1'b1;
    endcase

    full_d = (cnt_d == CW'(FIFO_DEPTH));
    busy_d = (cnt_d != '0) || (state_d != TX_IDLE);
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (accept) mem_q[wr_q] <= i_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_full = full_q;
  assign o_busy = busy_q;

endmodule

// File: rtl/mmio_resp.sv
// Data-memory responder: forwards RAM traffic below MMIO_BASE and serves the
// console, cycle counter and status registers inside the 256-byte MMIO window.
// Ports:
//  i_clk, i_rst          clock, synchronous active-high reset
//  i_action/i_addr/i_val core load/store request
//  o_val                 load data (combinational)
//  o_ram_action/addr/val request forwarded to ram (NOP for MMIO addresses)
//  i_ram_val             ram read data
//  o_tx                  serial console line
module mmio_resp
  import mmio_resp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_DIV   = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_action,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_val,
  output logic [XLEN-1:0] o_val,
  output logic [1:0]      o_ram_action,
  output logic [XLEN-1:0] o_ram_addr,
  output logic [XLEN-1:0] o_ram_val,
  input  logic [XLEN-1:0] i_ram_val,
  output logic            o_tx
);

  logic            mmio, st, push, full, busy, ovf_pulse;
  logic [7:0]      off;
  logic [XLEN-1:0] cycle_q, cycle_d, reg_mux;
  logic            ovf_q, ovf_d;
  con_stat_t       stat;

  con_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_con_tx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_byte      (i_val[7:0]),
    .o_full      (full),
    .o_busy      (busy),
    .o_ovf_pulse (ovf_pulse),
    .o_tx        (o_tx)
  );

  // Address decode, register updates and load mux.
  always_comb begin
    mmio = (i_addr >= MMIO_BASE);
    off  = i_addr[7:0];
    st   = mmio && (i_action == RAM_ST);
    push = st && (off == MMIO_CON_DATA);

    cycle_d = (st && (off == MMIO_CYCLE)) ? i_val : cycle_q + XLEN'(1);

    ovf_d = ovf_q;
    if (st && (off == MMIO_CON_STAT)) ovf_d = 1'b0;
    else if (ovf_pulse)               ovf_d = 1'b1;

    stat      = '0;
    stat.ovf  = ovf_q;
    stat.full = full;
    stat.busy = busy;

    unique case (off)
      MMIO_CON_STAT: reg_mux = stat;
      MMIO_CYCLE:    reg_mux = cycle_q;
      default:       reg_mux = '0;
    endcase

    if (mmio) o_val = (i_action == RAM_LD) ? reg_mux : '0;
    else      o_val = i_ram_val;

    o_ram_action = mmio ? RAM_NOP : i_action;
    o_ram_addr   = i_addr;
    o_ram_val    = i_val;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_resp.sv
// Self-checking bench for mmio_resp. The console is checked against a
// frame-level model: a byte queue, the start cycle of the frame on the line,
// and the bit pattern of a 10-bit 8N1 frame derived from the cycle offset.
module tb_mmio_resp;
  import mmio_resp_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BAUD  = 16;
  localparam int          FRAME = 10 * BAUD;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          SCHED = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  action = RAM_NOP;
  logic [31:0] addr = '0, val = '0, ram_rd = '0;
  logic [31:0] o_val, ram_addr, ram_wval;
  logic [1:0]  ram_action;
  logic        tx;

  always #5 clk = ~clk;

  mmio_resp #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_DIV   (BAUD),
    .MMIO_BASE  (BASE)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_action     (action),
    .i_addr       (addr),
    .i_val        (val),
    .o_val        (o_val),
    .o_ram_action (ram_action),
    .o_ram_addr   (ram_addr),
    .o_ram_val    (ram_wval),
    .i_ram_val    (ram_rd),
    .o_tx         (tx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Console model state
  logic [7:0] mq[$];
  int         m_cur, m_start;
  bit         m_active, m_ovf;
  logic [7:0] m_byte;
  int         sched_op [SCHED];   // 0: read CON_STAT, 1: push byte, 2: write CON_STAT
  logic [7:0] sched_byte [SCHED];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [31:0] ad, input logic [31:0] v);
    action = a;
    addr   = ad;
    val    = v;
    #1;
  endtask

  function automatic logic m_tx();
    int j;
    if (!m_active) return 1'b1;
    j = m_cur - m_start;
    if (j >= FRAME) return 1'b1;
    if (j < BAUD) return 1'b0;
    if (j < 9 * BAUD) return m_byte[(j - BAUD) / BAUD];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_stat();
    logic busy, full;
    busy = (mq.size() != 0) || (m_active && (m_cur - m_start) < FRAME);
    full = (mq.size() == DEPTH);
    return {29'b0, m_ovf, full, busy};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur    = 0;
    m_start  = 0;
    m_active = 0;
    m_ovf    = 0;
    for (int i = 0; i < SCHED; i++) begin
      sched_op[i]   = 0;
      sched_byte[i] = '0;
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_edge(input int op, input logic [7:0] b);
    bit pop_now;
    pop_now = (mq.size() != 0) && (!m_active || (m_cur + 1 - m_start) >= FRAME);
    if (pop_now) begin
      m_byte   = mq.pop_front();
      m_start  = m_cur + 1;
      m_active = 1;
    end
    if (op == 1) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else                   m_ovf = 1;
    end
    if (op == 2) m_ovf = 0;
    m_cur++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(RAM_NOP, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Play the console schedule for n cycles, checking line and status each cycle.
  task automatic run_tx(input int n);
    for (int i = 0; i < n; i++) begin
      int         op;
      logic [7:0] b;
      op = (m_cur < SCHED) ? sched_op[m_cur] : 0;
      b  = (m_cur < SCHED) ? sched_byte[m_cur] : 8'h00;
      case (op)
        1:       drive(RAM_ST, BASE + 32'(MMIO_CON_DATA), {$urandom_range(0, 255), b} & 32'h0000_FFFF);
        2:       drive(RAM_ST, BASE + 32'(MMIO_CON_STAT), $urandom);
        default: drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), $urandom);
      endcase
      n_tests++;
      if (tx !== m_tx()) begin
        n_fail++;
        $display("FAIL tx_line cycle=%0d got=%b exp=%b", m_cur, tx, m_tx());
      end
      if (op == 0) begin
        n_tests++;
        if (o_val !== m_stat()) begin
          n_fail++;
          $display("FAIL con_stat cycle=%0d got=%h exp=%h", m_cur, o_val, m_stat());
        end
      end
      model_edge(op, b);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    drive(RAM_LD, BASE + 32'(MMIO_CYCLE), 32'h0);
    n_tests++;
    if (o_val !== 32'h0) begin n_fail++; $display("FAIL reset_cycle got=%h exp=0", o_val); end
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx); end
    drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), 32'h0);
    n_tests++;
    if (o_val !== 32'h0) begin n_fail++; $display("FAIL reset_stat got=%h exp=0", o_val); end
    tick();
    drive(RAM_LD, BASE + 32'(MMIO_CYCLE), 32'h0);
    n_tests++;
    if (o_val !== 32'h1) begin n_fail++; $display("FAIL reset_cycle_inc got=%h exp=1", o_val); end
    tick();
  endtask

  task automatic test_passthrough();
    logic [31:0] a, v, r;
    logic [1:0]  act;
    drive(RAM_ST, 32'h100, 32'h1234);
    n_tests++;
    if (ram_action !== RAM_ST || ram_addr !== 32'h100 || ram_wval !== 32'h1234) begin
      n_fail++;
      $display("FAIL pass_st got=%0d/%h/%h exp=%0d/100/1234", ram_action, ram_addr, ram_wval, RAM_ST);
    end
    tick();
    r = $urandom;
    ram_rd = r;
    drive(RAM_LD, 32'h100, 32'h0);
    n_tests++;
    if (ram_action !== RAM_LD || o_val !== r) begin
      n_fail++;
      $display("FAIL pass_ld got=%0d/%h exp=%0d/%h", ram_action, o_val, RAM_LD, r);
    end
    drive(RAM_ST, BASE, 32'h0);
    n_tests++;
    if (ram_action !== RAM_NOP) begin
      n_fail++;
      $display("FAIL pass_base_nop got=%0d exp=%0d", ram_action, RAM_NOP);
    end
    action = RAM_NOP;
    tick();
    for (int i = 0; i < 8; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      v = $urandom;
      r = $urandom;
      act = 2'($urandom_range(0, 2));
      ram_rd = r;
      drive(act, a, v);
      n_tests++;
      if (ram_action !== act || ram_addr !== a || ram_wval !== v ||
          (act == RAM_LD && o_val !== r)) begin
        n_fail++;
        $display("FAIL pass_rand got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", ram_action, ram_addr, ram_wval, o_val, act, a, v, r);
      end
      drive(RAM_LD, BASE | 32'($urandom_range(0, 255)), v);
      n_tests++;
      if (ram_action !== RAM_NOP) begin
        n_fail++;
        $display("FAIL pass_mmio_nop got=%0d exp=%0d", ram_action, RAM_NOP);
      end
      tick();
    end
  endtask

  task automatic test_cycle();
    logic [31:0] v;
    for (int it = 0; it < 6; it++) begin
      v = (it == 0) ? 32'hFFFF_FFFE : $urandom;
      drive(RAM_ST, BASE + 32'(MMIO_CYCLE), v);
      tick();
      for (int k = 0; k < 4; k++) begin
        drive(RAM_LD, BASE + 32'(MMIO_CYCLE), 32'h0);
        n_tests++;
        if (o_val !== v + 32'(k)) begin
          n_fail++;
          $display("FAIL cycle_count k=%0d got=%h exp=%h", k, o_val, v + 32'(k));
        end
        tick();
      end
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    sched_op[0]   = 1;
    sched_byte[0] = 8'h55;
    run_tx(FRAME + 20);
    sched_op[m_cur]   = 1;
    sched_byte[m_cur] = 8'($urandom);
    run_tx(FRAME + 20);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sched_op[i]   = 1;
      sched_byte[i] = 8'($urandom);
    end
    run_tx(10);
    drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), 32'h0);
    n_tests++;
    if (o_val !== 32'h7) begin n_fail++; $display("FAIL ovf_stat got=%h exp=7", o_val); end
    run_tx(9 * FRAME);
    sched_op[m_cur] = 2;
    run_tx(3);
    drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), 32'h0);
    n_tests++;
    if (o_val !== 32'h0) begin n_fail++; $display("FAIL ovf_clear got=%h exp=0", o_val); end
  endtask

  task automatic test_back_to_back();
    int r;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 99);
      sched_op[c]   = (r < 6) ? 1 : ((r == 6) ? 2 : 0);
      sched_byte[c] = 8'($urandom);
    end
    run_tx(2000);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    sched_op[0] = 1; sched_byte[0] = 8'($urandom);
    sched_op[1] = 1; sched_byte[1] = 8'($urandom);
    run_tx(2 + BAUD + 3 * BAUD + 5);
    rst = 1'b1;
    drive(RAM_NOP, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    model_reset();
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
    drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), 32'h0);
    n_tests++;
    if (o_val !== 32'h0) begin n_fail++; $display("FAIL rst_mid_stat got=%h exp=0", o_val); end
    drive(RAM_LD, BASE + 32'(MMIO_CYCLE), 32'h0);
    n_tests++;
    if (o_val !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cycle got=%h exp=0", o_val); end
    run_tx(2 * FRAME);
  endtask

  task automatic test_unmapped();
    logic [31:0] off;
    int          e;
    do_reset();
    drive(RAM_ST, BASE + 32'(MMIO_CYCLE), 32'h1000);
    tick();
    e = 0;
    for (int i = 0; i < 6; i++) begin
      off = (i == 0) ? 32'h0C : ((i == 1) ? 32'hFC : ((i == 2) ? 32'h00 : 32'($urandom_range(3, 63)) * 4));
      drive(RAM_LD, BASE + off, 32'h0);
      n_tests++;
      if (o_val !== 32'h0) begin n_fail++; $display("FAIL unmapped_ld off=%h got=%h exp=0", off, o_val); end
      tick(); e++;
    end
    for (int i = 0; i < 2; i++) begin
      off = (i == 0) ? 32'h0C : 32'hFC;
      drive(RAM_ST, BASE + off, $urandom);
      n_tests++;
      if (ram_action !== RAM_NOP) begin n_fail++; $display("FAIL unmapped_st_nop got=%0d exp=0", ram_action); end
      tick(); e++;
    end
    drive(RAM_LD, BASE + 32'(MMIO_CYCLE), 32'h0);
    n_tests++;
    if (o_val !== 32'h1000 + 32'(e)) begin n_fail++; $display("FAIL unmapped_cycle got=%h exp=%h", o_val, 32'h1000 + 32'(e)); end
    drive(RAM_LD, BASE + 32'(MMIO_CON_STAT), 32'h0);
    n_tests++;
    if (o_val !== 32'h0 || tx !== 1'b1) begin n_fail++; $display("FAIL unmapped_stat got=%h/%b exp=0/1", o_val, tx); end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_cycle();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_unmapped();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
